// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job scheduler and its engine.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT   = 8;
  localparam int GCD_TIMEOUT_DEFAULT = 600;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_job_scheduler_if.sv
// Operand input stream and result output stream of the GCD job scheduler.
interface gcd_job_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_err;

  // master: producer of operand pairs and consumer of results
  modport master (
    output in_valid, in_p, in_q, out_ready,
    input  in_ready, out_valid, out_r, out_err
  );

  modport slave (
    input  in_valid, in_p, in_q, out_ready,
    output in_ready, out_valid, out_r, out_err
  );
endinterface

// File: rtl/gcd_pair_fifo.sv
// Show-ahead FIFO of packed {P,Q} operand pairs; head is visible on rd_data.
module gcd_pair_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Queues (P,Q) pairs, runs them one at a time on gcd_calc, and streams results
// out in order; zero operands bypass the engine, a watchdog bounds each job.
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  gcd_job_scheduler_if.slave   io,
  output logic                 gcd_start,
  output logic [WIDTH-1:0]     gcd_p,
  output logic [WIDTH-1:0]     gcd_q,
  input  logic [WIDTH-1:0]     gcd_r,
  input  logic                 gcd_done
);

  // state     | meaning
  // ST_IDLE   | waiting for a queued pair; pops head when FIFO non-empty
  // ST_LAUNCH | one-cycle gcd_start pulse, watchdog cleared
  // ST_WAIT   | engine running; leave on gcd_done or watchdog expiry
  // ST_HOLD   | result presented on out_valid until out_ready

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int CW  = $clog2(DEPTH + 1);

  gcd_state_e         state;
  gcd_state_e         state_nxt;

  logic [2*WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0]   head_p;
  logic [WIDTH-1:0]   head_q;
  logic               head_zero;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               fifo_pop;

  logic [WDW-1:0]     wd;
  logic               wd_expired;
  logic [WIDTH-1:0]   out_r_q;
  logic               out_err_q;
  logic               out_valid;

  gcd_pair_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (io.in_valid),
    .wr_data ({io.in_p, io.in_q}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_p     = fifo_head[2*WIDTH-1:WIDTH];
  assign head_q     = fifo_head[WIDTH-1:0];
  assign head_zero  = (head_p == '0) || (head_q == '0);
  assign wd_expired = (wd == WDW'(TIMEOUT));

  assign io.in_ready  = !fifo_full;
  assign io.out_valid = out_valid;
  assign io.out_r     = out_r_q;
  assign io.out_err   = out_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = head_zero ? ST_HOLD : ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (gcd_done || wd_expired) state_nxt = ST_HOLD;
      ST_HOLD:   if (io.out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = 1'b0;
    gcd_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE:   fifo_pop  = !fifo_empty;
      ST_LAUNCH: gcd_start = 1'b1;
      ST_HOLD:   out_valid = 1'b1;
      default:   ;
    endcase
  end

  // gcd_done takes priority over a watchdog expiring in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcd_p     <= '0;
      gcd_q     <= '0;
      out_r_q   <= '0;
      out_err_q <= 1'b0;
      wd        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            gcd_p <= head_p;
            gcd_q <= head_q;
            if (head_zero) begin
              out_r_q   <= head_p | head_q;
              out_err_q <= 1'b0;
            end
          end
        end
        ST_LAUNCH: wd <= '0;
        ST_WAIT: begin
          if (gcd_done) begin
            out_r_q   <= gcd_r;
            out_err_q <= 1'b0;
          end else if (wd_expired) begin
            out_r_q   <= '0;
            out_err_q <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) fifo_full == (fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler with a behavioural gcd_calc stand-in.
module tb_gcd_job_scheduler;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TO = 20;

  localparam logic [7:0] BB_P [6] = '{8'd12, 8'd7, 8'd9, 8'd8, 8'd15, 8'd21};
  localparam logic [7:0] BB_Q [6] = '{8'd18, 8'd5, 8'd3, 8'd8, 8'd10, 8'd14};
  localparam logic [7:0] BB_R [6] = '{8'd6,  8'd1, 8'd3, 8'd8, 8'd5,  8'd7};
  localparam logic [7:0] RD_P [4] = '{8'd12, 8'd35, 8'd0, 8'd27};
  localparam logic [7:0] RD_Q [4] = '{8'd8,  8'd21, 8'd5, 8'd18};
  localparam logic [7:0] RD_R [4] = '{8'd4,  8'd7,  8'd5, 8'd9};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         gcd_start;
  logic [W-1:0] gcd_p, gcd_q, gcd_r;
  logic         gcd_done;

  logic         eng_hang = 1'b0;
  logic         eng_busy, eng_done;
  logic [W-1:0] eng_a, eng_b, eng_r;
  int           eng_cnt;
  logic         spur_done = 1'b0;
  logic [W-1:0] spur_r = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  gcd_job_scheduler_if #(.WIDTH(W)) sif ();

  gcd_job_scheduler #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (sif),
    .gcd_start (gcd_start),
    .gcd_p     (gcd_p),
    .gcd_q     (gcd_q),
    .gcd_r     (gcd_r),
    .gcd_done  (gcd_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  assign gcd_done = eng_done | spur_done;
  assign gcd_r    = spur_done ? spur_r : eng_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0; eng_done <= 1'b0; eng_r <= '0;
      eng_a <= '0; eng_b <= '0; eng_cnt <= 0;
    end else begin
      eng_done <= 1'b0;
      if (gcd_start) begin
        eng_busy <= 1'b1; eng_a <= gcd_p; eng_b <= gcd_q; eng_cnt <= 3;
      end else if (eng_hang) begin
        eng_busy <= 1'b0;
      end else if (eng_busy) begin
        if (eng_cnt == 0) begin
          eng_busy <= 1'b0; eng_done <= 1'b1; eng_r <= gcd_fn(eng_a, eng_b);
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) if (!rst && gcd_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] p, input logic [W-1:0] q);
    int t = 0;
    sif.in_valid = 1'b1; sif.in_p = p; sif.in_q = q;
    while (!sif.in_ready && t < 100) begin tick(); t++; end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL push_timeout: in_ready stayed 0 for pair (%0d,%0d)", p, q);
    end
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output bit prev_done);
    int t = 0;
    prev_done = 1'b0;
    while (!sif.out_valid && t < budget) begin prev_done = gcd_done; tick(); t++; end
    ok = sif.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.in_valid = 1'b0; sif.in_p = '0; sif.in_q = '0; sif.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (sif.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", sif.in_ready); else n_pass++;
    n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", sif.out_valid); else n_pass++;
    n_checks++; if (sif.out_r !== 8'd0) $display("FAIL rst_out_r: got %0d want 0", sif.out_r); else n_pass++;
    n_checks++; if (sif.out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", sif.out_err); else n_pass++;
    n_checks++; if (gcd_start !== 1'b0) $display("FAIL rst_gcd_start: got %b want 0", gcd_start); else n_pass++;
    n_checks++; if (gcd_p !== 8'd0 || gcd_q !== 8'd0) $display("FAIL rst_gcd_pq: got %0d,%0d want 0,0", gcd_p, gcd_q); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s0;
    bit ok, pd;
    sif.out_ready = 1'b1;
    s0 = start_cnt;
    push(8'd6, 8'd4);
    tick();
    n_checks++; if (gcd_start !== 1'b1) $display("FAIL basic_start_latency: gcd_start=%b want 1 one edge after accept", gcd_start); else n_pass++;
    wait_valid(50, ok, pd);
    n_checks++; if (!ok) $display("FAIL basic_valid_timeout: out_valid got 0 want 1"); else n_pass++;
    n_checks++; if (pd !== 1'b1) $display("FAIL basic_done_to_valid: gcd_done prior cycle got %b want 1", pd); else n_pass++;
    n_checks++; if (sif.out_r !== 8'd2) $display("FAIL basic_out_r: got %0d want 2", sif.out_r); else n_pass++;
    n_checks++; if (sif.out_err !== 1'b0) $display("FAIL basic_out_err: got %b want 0", sif.out_err); else n_pass++;
    tick();
    n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", sif.out_valid); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 1) $display("FAIL basic_start_count: got %0d want 1", start_cnt - s0); else n_pass++;
  endtask

  task automatic test_zero_bypass();
    int s0;
    sif.out_ready = 1'b1;
    s0 = start_cnt;
    push(8'd0, 8'd9);
    n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL zb1_early: out_valid got %b want 0", sif.out_valid); else n_pass++;
    tick();
    n_checks++; if (sif.out_valid !== 1'b1 || sif.out_r !== 8'd9 || sif.out_err !== 1'b0)
      $display("FAIL zb1_result: valid=%b r=%0d err=%b want 1,9,0", sif.out_valid, sif.out_r, sif.out_err); else n_pass++;
    tick();
    push(8'd0, 8'd0);
    tick();
    n_checks++; if (sif.out_valid !== 1'b1 || sif.out_r !== 8'd0 || sif.out_err !== 1'b0)
      $display("FAIL zb2_result: valid=%b r=%0d err=%b want 1,0,0", sif.out_valid, sif.out_r, sif.out_err); else n_pass++;
    tick();
    n_checks++; if (start_cnt - s0 !== 0) $display("FAIL zb_no_start: gcd_start pulses got %0d want 0", start_cnt - s0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int got = 0;
    bit pend, take;
    logic [W-1:0] res [6];
    for (int i = 0; i < 6; i++) res[i] = '0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sif.in_valid = 1'b1; sif.in_p = BB_P[i]; sif.in_q = BB_Q[i];
      if (!sif.in_ready) break;
      tick();
      acc++;
    end
    n_checks++; if (acc !== 5) $display("FAIL b2b_accepted: got %0d want 5", acc); else n_pass++;
    n_checks++; if (sif.in_ready !== 1'b0) $display("FAIL b2b_in_ready_6th: got %b want 0", sif.in_ready); else n_pass++;
    pend = (acc < 6);
    if (!pend) sif.in_valid = 1'b0;
    sif.out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 6; c++) begin
      take = pend && sif.in_ready;
      if (sif.out_valid && sif.out_ready) begin res[got] = sif.out_r; got++; end
      tick();
      if (take) begin sif.in_valid = 1'b0; pend = 1'b0; end
    end
    sif.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (res[i] !== BB_R[i]) $display("FAIL b2b_order_%0d: got %0d want %0d", i, res[i], BB_R[i]); else n_pass++;
    end
  endtask

  task automatic test_random_drain();
    int got = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_r = '0;
    logic [W-1:0] res [4];
    logic rdy;
    for (int i = 0; i < 4; i++) res[i] = '0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(RD_P[i], RD_Q[i]);
    for (int c = 0; c < 400 && got < 4; c++) begin
      rdy = 1'($urandom_range(0, 1));
      sif.out_ready = rdy;
      if (prev_stall) begin
        n_checks++;
        if (sif.out_valid !== 1'b1 || sif.out_r !== prev_r)
          $display("FAIL drain_stable: valid=%b r=%0d want 1,%0d", sif.out_valid, sif.out_r, prev_r);
        else n_pass++;
      end
      if (sif.out_valid && rdy) begin
        if (got < 4) res[got] = sif.out_r;
        got++;
      end
      prev_stall = sif.out_valid && !rdy;
      prev_r = sif.out_r;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (res[i] !== RD_R[i]) $display("FAIL drain_order_%0d: got %0d want %0d", i, res[i], RD_R[i]); else n_pass++;
    end
    sif.out_ready = 1'b1;
    repeat (10) tick();
    n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL drain_no_dup: out_valid got %b want 0", sif.out_valid); else n_pass++;
  endtask

  task automatic test_spurious_done();
    bit ok, pd;
    sif.out_ready = 1'b0;
    spur_r = 8'h55; spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) tick();
    n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL spur_idle: out_valid got %b want 0", sif.out_valid); else n_pass++;
    push(8'd14, 8'd21);
    wait_valid(50, ok, pd);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    n_checks++; if (sif.out_valid !== 1'b1 || sif.out_r !== 8'd7)
      $display("FAIL spur_hold: valid=%b r=%0d want 1,7", sif.out_valid, sif.out_r); else n_pass++;
    sif.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int t = 0;
    bit ok, pd;
    eng_hang = 1'b1;
    sif.out_ready = 1'b0;
    push(8'd10, 8'd4);
    while (!gcd_start && t < 10) begin tick(); t++; end
    n_checks++; if (gcd_start !== 1'b1) $display("FAIL to_launch: gcd_start got %b want 1", gcd_start); else n_pass++;
    for (int k = 1; k <= TO + 2; k++) begin
      tick();
      if (k == TO + 1) begin
        n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL to_early: out_valid got %b want 0 at %0d edges", sif.out_valid, k); else n_pass++;
      end
    end
    n_checks++; if (sif.out_valid !== 1'b1 || sif.out_err !== 1'b1 || sif.out_r !== 8'd0)
      $display("FAIL to_result: valid=%b err=%b r=%0d want 1,1,0", sif.out_valid, sif.out_err, sif.out_r); else n_pass++;
    sif.out_ready = 1'b1;
    tick();
    eng_hang = 1'b0;
    push(8'd9, 8'd6);
    wait_valid(50, ok, pd);
    n_checks++; if (!ok || sif.out_r !== 8'd3 || sif.out_err !== 1'b0)
      $display("FAIL to_next_job: valid=%b r=%0d err=%b want 1,3,0", ok, sif.out_r, sif.out_err); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_job();
    int s0, nv = 0;
    eng_hang = 1'b1;
    sif.out_ready = 1'b0;
    push(8'd12, 8'd18);
    repeat (3) tick();
    push(8'd7, 8'd5);
    push(8'd9, 8'd3);
    push(8'd8, 8'd8);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0 || sif.out_err !== 1'b0 || sif.out_r !== 8'd0)
      $display("FAIL midrst_stream: in_ready=%b valid=%b err=%b r=%0d want 1,0,0,0", sif.in_ready, sif.out_valid, sif.out_err, sif.out_r); else n_pass++;
    n_checks++; if (gcd_start !== 1'b0 || gcd_p !== 8'd0 || gcd_q !== 8'd0)
      $display("FAIL midrst_engine: start=%b p=%0d q=%0d want 0,0,0", gcd_start, gcd_p, gcd_q); else n_pass++;
    tick();
    rst = 1'b0;
    eng_hang = 1'b0;
    sif.out_ready = 1'b1;
    s0 = start_cnt;
    for (int c = 0; c < 40; c++) begin
      if (sif.out_valid) nv++;
      tick();
    end
    n_checks++; if (nv !== 0) $display("FAIL midrst_no_result: out_valid cycles got %0d want 0", nv); else n_pass++;
    n_checks++; if (start_cnt - s0 !== 0) $display("FAIL midrst_no_start: gcd_start pulses got %0d want 0", start_cnt - s0); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_bypass();
    test_back_to_back();
    test_random_drain();
    test_spurious_done();
    test_timeout();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
